mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Two-client arbiter for the simple memory interface (`mem_req_*` / `mem_wr_*` / `mem_rd_*`) that the AXI bridges present to the TSIM host memory.
- Lets two independently generated HLS accelerators, each behind its own bridge, share one host memory port.
- Grants whole transactions in round-robin order and registers each request before reissuing it downstream.
- Routes write beats from the owning client and read beats back to it until the transaction's beat count completes.

## Interface
Parameters:
- `MEM_LEN_BITS`, 8, burst length field width (len = beats − 1)
- `MEM_ADDR_BITS`, 32, address width
- `MEM_DATA_BITS`, 64, data beat width
- `TIMEOUT`, 1024, idle-cycle limit in a write data phase (used only with `MEM_ARB_TIMEOUT_EN`)

Ports (`cN` = `c0`, `c1`; each client group is identical):
- `clock`  in  1  sole clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (low = reset asserted)
- `cN_req_valid`  in  1  client request
- `cN_req_ready`  out  1  request accepted this cycle
- `cN_req_opcode`  in  1  0 = read, 1 = write
- `cN_req_len`  in  MEM_LEN_BITS  beats − 1
- `cN_req_addr`  in  MEM_ADDR_BITS  byte address
- `cN_wr_valid`  in  1  write beat valid
- `cN_wr_ready`  out  1  write beat accepted
- `cN_wr_bits`  in  MEM_DATA_BITS  write data
- `cN_rd_valid`  out  1  read beat valid
- `cN_rd_bits`  out  MEM_DATA_BITS  read data
- `cN_rd_ready`  in  1  client accepts read beat
- `mem_req_valid`  out  1  one-cycle downstream request
- `mem_req_opcode`  out  1  latched opcode
- `mem_req_len`  out  MEM_LEN_BITS  latched len
- `mem_req_addr`  out  MEM_ADDR_BITS  latched addr
- `mem_wr_valid`  out  1  downstream write beat
- `mem_wr_bits`  out  MEM_DATA_BITS  downstream write data
- `mem_rd_valid`  in  1  downstream read beat
- `mem_rd_bits`  in  MEM_DATA_BITS  downstream read data
- `mem_rd_ready`  out  1  read beat consumed
- `timeout`  out  1  one-cycle pulse on write abort (constant 0 without the macro)

## Operation
- **States:** IDLE, ISSUE, READ, WRITE.
- **Registers:** `grant` (1 bit), `last` (1 bit), `op`, `len`, `addr`, `beat` counter (MEM_LEN_BITS), timeout counter (32 bits).
- **IDLE**
  - Winner is the only requester; if both request, the winner is the client ≠ `last`.
  - The winner's `cN_req_ready` = 1 combinationally; the loser's is 0.
  - On accept: latch opcode/len/addr, set `grant` = `last` = winner, clear `beat`, go to ISSUE.
- **ISSUE**
  - `mem_req_valid` = 1 with the latched fields for exactly one cycle.
  - Next state is READ if `op` = 0, WRITE if `op` = 1.
- **READ**
  - `cgrant_rd_valid` = `mem_rd_valid`; `cgrant_rd_bits` = `mem_rd_bits`; `mem_rd_ready` = `cgrant_rd_ready`.
  - A beat is counted when `mem_rd_valid & mem_rd_ready`.
  - When a beat is counted with `beat == len`, go to IDLE; otherwise `beat++`.
- **WRITE**
  - `cgrant_wr_ready` = 1; `mem_wr_valid` = `cgrant_wr_valid`; `mem_wr_bits` = `cgrant_wr_bits`.
  - A beat is counted when `cgrant_wr_valid`; the `beat == len` beat returns to IDLE.
- **Non-granted client:** all outputs to it are 0 (`rd_bits` is 0, not pass-through).
- **Outside READ/WRITE:** `mem_rd_ready` = 0 and `mem_wr_valid` = 0.
- **len = 0:** a single-beat transaction is legal.
- **len = 2^MEM_LEN_BITS − 1:** the `beat` compare never wraps before done.

## Timing
- **Reset value of every output:** 0 (`cN_req_ready` is asserted combinationally in IDLE for whichever client requests, including the cycle after reset release).
- **Internal reset values:** state = IDLE, `last` = 1 (c0 wins the first tie), all counters 0.
- **Accept-to-downstream latency:** request accepted at cycle t, `mem_req_valid` at t+1, first data beat possible at t+2.
- **Back-to-back transactions:** earliest next accept is the cycle after the final beat (IDLE), so the minimum is 3 cycles per single-beat transaction.
- **Fairness:** with continuous requests from both clients, grants alternate strictly c0, c1, c0, ….
- **Reset mid-transaction:** asserting `reset` immediately forces IDLE and all outputs to 0; the in-flight transaction is dropped and no further beats are forwarded.

## Configuration
- **Macro:** `MEM_ARB_TIMEOUT_EN`.
- **Defined:**
  - The timeout counter clears in IDLE and increments every WRITE cycle with `cgrant_wr_valid` = 0.
  - On reaching `TIMEOUT`: go to IDLE, pulse `timeout` for one cycle, release the grant.
  - `last` keeps the timed-out client, so the other client wins any tie.
  - Purpose: recovers from HLS masters that issue a write request and never send data.
- **Undefined:** counter logic is absent, WRITE waits indefinitely, and `timeout` is tied to 0.

## Test plan
- **Single read:** c0 read, addr 0x100, len 3; memory returns 4 beats 0xA0–0xA3 with `c0_rd_ready` = 1 → `mem_req_valid` one cycle after accept with len 3; c0 receives 4 beats in order; IDLE after the 4th.
- **Tie arbitration:** c0 and c1 both request a len-0 write from reset → c0 granted first, c1 next, then c0; `cN_req_ready` never high for both clients in the same cycle.
- **Read backpressure:** `c1_rd_ready` low for 5 cycles during a len-1 read → `mem_rd_ready` = 0 in those cycles, the beat count holds, and completion occurs only after 2 accepted beats.
- **Write passthrough:** c1 writes len 1, data 0xDEAD then 0xBEEF with a 2-cycle gap → `mem_wr_valid` exactly twice with those bits; c0 outputs remain 0 throughout.
- **Timeout (with macro, TIMEOUT = 16):** c0 write, no `wr_valid` → `timeout` pulses 16 cycles into WRITE, state returns to IDLE, and a waiting c1 is granted next. Without the macro, the bench confirms the block stays in WRITE.
- **Reset mid-read:** `reset` driven low at beat 2 of a len-7 read → all outputs 0 in the same cycle; after release, a new c1 request is accepted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-client arbiter in front of one simple memory port.
//
// Two clients (c0, c1) share the downstream mem_req/mem_wr/mem_rd
// interface. Whole transactions are granted in round-robin order. The
// winning request is registered and reissued downstream one cycle later.
// Write beats are then routed from the owner, and read beats back to it,
// until len+1 beats have been counted.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a write data phase
// after TIMEOUT cycles without write data. In that case the `timeout`
// output pulses for one cycle. Without the macro, `timeout` is constant 0.
//
// Handshake semantics: a request is taken when cN_req_valid & cN_req_ready.
// A read beat moves when mem_rd_valid & mem_rd_ready. A write beat moves
// whenever the owner's cN_wr_valid is high, because the downstream port
// has no write backpressure.
//
// Ports:
//   clock, reset            clock; asynchronous active-low reset
//   cN_req_*                client request channel (valid/ready/opcode/len/addr)
//   cN_wr_*                 client write data channel (valid/ready/bits)
//   cN_rd_*                 client read data channel (valid/bits/ready)
//   mem_req_*               one-cycle downstream request with latched fields
//   mem_wr_valid/bits       downstream write beat
//   mem_rd_valid/bits/ready downstream read beat
//   timeout                 one-cycle pulse on write abort
//   dbg_state               current FSM state (0 IDLE, 1 ISSUE, 2 READ, 3 WRITE)
module mem_arbiter #(
   parameter int MEM_LEN_BITS  = 8,
   parameter int MEM_ADDR_BITS = 32,
   parameter int MEM_DATA_BITS = 64,
   parameter int TIMEOUT       = 1024
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     c0_req_valid,
   output logic                     c0_req_ready,
   input  logic                     c0_req_opcode,
   input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
   input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
   input  logic                     c0_wr_valid,
   output logic                     c0_wr_ready,
   input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
   output logic                     c0_rd_valid,
   output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
   input  logic                     c0_rd_ready,
   input  logic                     c1_req_valid,
   output logic                     c1_req_ready,
   input  logic                     c1_req_opcode,
   input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
   input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
   input  logic                     c1_wr_valid,
   output logic                     c1_wr_ready,
   input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
   output logic                     c1_rd_valid,
   output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
   input  logic                     c1_rd_ready,
   output logic                     mem_req_valid,
   output logic                     mem_req_opcode,
   output logic [MEM_LEN_BITS-1:0]  mem_req_len,
   output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
   output logic                     mem_wr_valid,
   output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
   input  logic                     mem_rd_valid,
   input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
   output logic                     mem_rd_ready,
   output logic                     timeout,
   output logic [1:0]               dbg_state
);

   // A TIMEOUT below 1 would make the abort compare wrap.
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic                     grant_q, grant_d;
   logic                     last_q, last_d;
   logic                     op_q, op_d;
   logic [MEM_LEN_BITS-1:0]  len_q, len_d;
   logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [MEM_LEN_BITS-1:0]  beat_q, beat_d;

   logic                     winner;
   logic                     rd_ready_sel;
   logic                     wr_valid_sel;
   logic [MEM_DATA_BITS-1:0] wr_bits_sel;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
   logic [31:0] tmo_q, tmo_d;
`endif

   // On a tie the client that did not win last time gets the grant.
   assign winner       = (c0_req_valid & c1_req_valid) ? ~last_q : c1_req_valid;
   assign rd_ready_sel = grant_q ? c1_rd_ready : c0_rd_ready;
   assign wr_valid_sel = grant_q ? c1_wr_valid : c0_wr_valid;
   assign wr_bits_sel  = grant_q ? c1_wr_bits  : c0_wr_bits;
   assign dbg_state    = state_q;

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_d         = last_q;
      op_d           = op_q;
      len_d          = len_q;
      addr_d         = addr_q;
      beat_d         = beat_q;
      c0_req_ready   = 1'b0;
      c1_req_ready   = 1'b0;
      c0_wr_ready    = 1'b0;
      c1_wr_ready    = 1'b0;
      c0_rd_valid    = 1'b0;
      c1_rd_valid    = 1'b0;
      c0_rd_bits     = '0;
      c1_rd_bits     = '0;
      mem_req_valid  = 1'b0;
      mem_req_opcode = 1'b0;
      mem_req_len    = '0;
      mem_req_addr   = '0;
      mem_wr_valid   = 1'b0;
      mem_wr_bits    = '0;
      mem_rd_ready   = 1'b0;
      timeout        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_d          = tmo_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_d = '0;
`endif
            // req_ready is combinational here, so it is gated by reset
            // to keep every output low while reset is asserted.
            if (reset && (c0_req_valid || c1_req_valid)) begin
               c0_req_ready = ~winner;
               c1_req_ready = winner;
               op_d         = winner ? c1_req_opcode : c0_req_opcode;
               len_d        = winner ? c1_req_len    : c0_req_len;
               addr_d       = winner ? c1_req_addr   : c0_req_addr;
               grant_d      = winner;
               last_d       = winner;
               beat_d       = '0;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_req_valid  = 1'b1;
            mem_req_opcode = op_q;
            mem_req_len    = len_q;
            mem_req_addr   = addr_q;
            state_d        = op_q ? ST_WRITE : ST_READ;
         end
         ST_READ: begin
            mem_rd_ready = rd_ready_sel;
            if (grant_q) begin
               c1_rd_valid = mem_rd_valid;
               c1_rd_bits  = mem_rd_bits;
            end else begin
               c0_rd_valid = mem_rd_valid;
               c0_rd_bits  = mem_rd_bits;
            end
            if (mem_rd_valid && rd_ready_sel) begin
               if (beat_q == len_q) state_d = ST_IDLE;
               else                 beat_d  = beat_q + 1'b1;
            end
         end
         ST_WRITE: begin
            if (grant_q) c1_wr_ready = 1'b1;
            else         c0_wr_ready = 1'b1;
            mem_wr_valid = wr_valid_sel;
            mem_wr_bits  = wr_bits_sel;
            if (wr_valid_sel) begin
               if (beat_q == len_q) state_d = ST_IDLE;
               else                 beat_d  = beat_q + 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            // The counter accumulates idle cycles over the whole data
            // phase. last_q is left on the aborting client, so the other
            // client wins the next tie.
            else if (tmo_q == TMO_LAST) begin
               state_d = ST_IDLE;
               timeout = 1'b1;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= 1'b0;
         len_q   <= '0;
         addr_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         op_q    <= op_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random traffic.
// All scenarios are checked cycle by cycle against a transaction-level
// reference model that uses per-client request queues.
module tb_mem_arbiter;
   localparam int LB = 8;
   localparam int AB = 32;
   localparam int DB = 64;
   localparam int TO = 16;

   typedef struct packed {
      logic          op;
      logic [LB-1:0] len;
      logic [AB-1:0] addr;
   } req_t;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic          c0_req_valid, c0_req_ready, c0_req_opcode;
   logic [LB-1:0] c0_req_len;
   logic [AB-1:0] c0_req_addr;
   logic          c0_wr_valid, c0_wr_ready, c0_rd_valid, c0_rd_ready;
   logic [DB-1:0] c0_wr_bits, c0_rd_bits;
   logic          c1_req_valid, c1_req_ready, c1_req_opcode;
   logic [LB-1:0] c1_req_len;
   logic [AB-1:0] c1_req_addr;
   logic          c1_wr_valid, c1_wr_ready, c1_rd_valid, c1_rd_ready;
   logic [DB-1:0] c1_wr_bits, c1_rd_bits;
   logic          mem_req_valid, mem_req_opcode;
   logic [LB-1:0] mem_req_len;
   logic [AB-1:0] mem_req_addr;
   logic          mem_wr_valid, mem_rd_valid, mem_rd_ready, timeout;
   logic [DB-1:0] mem_wr_bits, mem_rd_bits;
   logic [1:0]    dbg_state;

   mem_arbiter #(
      .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB), .TIMEOUT(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready),
      .c0_req_opcode(c0_req_opcode), .c0_req_len(c0_req_len), .c0_req_addr(c0_req_addr),
      .c0_wr_valid(c0_wr_valid), .c0_wr_ready(c0_wr_ready), .c0_wr_bits(c0_wr_bits),
      .c0_rd_valid(c0_rd_valid), .c0_rd_bits(c0_rd_bits), .c0_rd_ready(c0_rd_ready),
      .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
      .c1_req_opcode(c1_req_opcode), .c1_req_len(c1_req_len), .c1_req_addr(c1_req_addr),
      .c1_wr_valid(c1_wr_valid), .c1_wr_ready(c1_wr_ready), .c1_wr_bits(c1_wr_bits),
      .c1_rd_valid(c1_rd_valid), .c1_rd_bits(c1_rd_bits), .c1_rd_ready(c1_rd_ready),
      .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
      .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
      .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
      .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
      .timeout(timeout), .dbg_state(dbg_state)
   );

   // ---------------- bench state ----------------
   int n_checks = 0;
   int n_fail   = 0;

   req_t          pq0[$];
   req_t          pq1[$];
   logic          wr_v   [2];
   logic [DB-1:0] wr_d   [2];
   logic          rd_rdy [2];
   logic          mem_rd_v;
   logic [DB-1:0] mem_rd_d;

   // Reference model: one outstanding transaction at a time
   bit   m_busy, m_issue, m_own, m_last;
   req_t m_req;
   int   m_left, m_stall;

   int            to_seen;
   bit            sb_en;
   logic [DB-1:0] exp_q[$];
   int            grant_log[$];

   // ---------------- scoreboard compare ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void push_req(input int c, input logic op, input int len,
                                    input logic [AB-1:0] addr);
      req_t r;
      r.op   = op;
      r.len  = LB'(len);
      r.addr = addr;
      if (c == 0) pq0.push_back(r);
      else        pq1.push_back(r);
   endfunction

   // ---------------- driver + per-cycle check ----------------
   // Called just after a falling edge. It drives the inputs, checks the
   // outputs, advances the model by one rising edge, and then waits for
   // the next falling edge.
   task automatic step();
      bit p0, p1, w;
      logic          e_rr0, e_rr1, e_mrv, e_mop, e_mrr, e_mwv, e_to;
      logic [LB-1:0] e_mlen;
      logic [AB-1:0] e_maddr;
      logic          e_rv0, e_rv1, e_wr0, e_wr1;
      logic [DB-1:0] e_rb0, e_rb1, e_mwb;
      logic [1:0]    e_st;

      c0_req_valid  = (pq0.size() > 0);
      c0_req_opcode = (pq0.size() > 0) ? pq0[0].op   : 1'b0;
      c0_req_len    = (pq0.size() > 0) ? pq0[0].len  : '0;
      c0_req_addr   = (pq0.size() > 0) ? pq0[0].addr : '0;
      c1_req_valid  = (pq1.size() > 0);
      c1_req_opcode = (pq1.size() > 0) ? pq1[0].op   : 1'b0;
      c1_req_len    = (pq1.size() > 0) ? pq1[0].len  : '0;
      c1_req_addr   = (pq1.size() > 0) ? pq1[0].addr : '0;
      c0_wr_valid = wr_v[0];   c0_wr_bits = wr_d[0];   c0_rd_ready = rd_rdy[0];
      c1_wr_valid = wr_v[1];   c1_wr_bits = wr_d[1];   c1_rd_ready = rd_rdy[1];
      mem_rd_valid = mem_rd_v; mem_rd_bits = mem_rd_d;
      #1;

      p0 = (pq0.size() > 0);
      p1 = (pq1.size() > 0);
      w  = (p0 && p1) ? ~m_last : p1;
      {e_rr0, e_rr1, e_mrv, e_mop, e_mrr, e_mwv, e_to} = '0;
      {e_rv0, e_rv1, e_wr0, e_wr1} = '0;
      e_mlen = '0; e_maddr = '0; e_rb0 = '0; e_rb1 = '0; e_mwb = '0; e_st = 2'd0;
      if (reset) begin
         if (!m_busy) begin
            if (p0 || p1) begin
               e_rr0 = ~w;
               e_rr1 = w;
            end
         end else if (m_issue) begin
            e_st = 2'd1; e_mrv = 1'b1;
            e_mop = m_req.op; e_mlen = m_req.len; e_maddr = m_req.addr;
         end else if (!m_req.op) begin
            e_st  = 2'd2;
            e_mrr = rd_rdy[m_own];
            if (m_own) begin e_rv1 = mem_rd_v; e_rb1 = mem_rd_d; end
            else       begin e_rv0 = mem_rd_v; e_rb0 = mem_rd_d; end
         end else begin
            e_st  = 2'd3;
            e_wr0 = ~m_own;
            e_wr1 = m_own;
            e_mwv = wr_v[m_own];
            e_mwb = wr_d[m_own];
`ifdef MEM_ARB_TIMEOUT_EN
            e_to  = !wr_v[m_own] && (m_stall == TO - 1);
`endif
         end
      end

      chk("c0_req_ready", c0_req_ready, e_rr0);
      chk("c1_req_ready", c1_req_ready, e_rr1);
      chk("mem_req_valid", mem_req_valid, e_mrv);
      chk("mem_req_opcode", mem_req_opcode, e_mop);
      chk("mem_req_len", mem_req_len, e_mlen);
      chk("mem_req_addr", mem_req_addr, e_maddr);
      chk("c0_rd_valid", c0_rd_valid, e_rv0);
      chk("c0_rd_bits", c0_rd_bits, e_rb0);
      chk("c1_rd_valid", c1_rd_valid, e_rv1);
      chk("c1_rd_bits", c1_rd_bits, e_rb1);
      chk("mem_rd_ready", mem_rd_ready, e_mrr);
      chk("c0_wr_ready", c0_wr_ready, e_wr0);
      chk("c1_wr_ready", c1_wr_ready, e_wr1);
      chk("mem_wr_valid", mem_wr_valid, e_mwv);
      chk("mem_wr_bits", mem_wr_bits, e_mwb);
      chk("timeout", timeout, e_to);
      chk("dbg_state", dbg_state, e_st);

      if (c0_req_ready && c0_req_valid) grant_log.push_back(0);
      if (c1_req_ready && c1_req_valid) grant_log.push_back(1);
      if (timeout) to_seen++;
      if (sb_en && mem_wr_valid) begin
         if (exp_q.size() == 0) chk("wr_extra_beat", 1, 0);
         else                   chk("wr_beat_data", mem_wr_bits, exp_q.pop_front());
      end

      // advance the model across the coming rising edge
      if (!reset) begin
         m_busy = 0; m_issue = 0; m_last = 1; m_stall = 0;
      end else if (!m_busy) begin
         if (p0 || p1) begin
            m_req   = w ? pq1.pop_front() : pq0.pop_front();
            m_own   = w;
            m_last  = w;
            m_busy  = 1;
            m_issue = 1;
            m_left  = int'(m_req.len) + 1;
            m_stall = 0;
         end
      end else if (m_issue) begin
         m_issue = 0;
      end else begin
         if (!m_req.op) begin
            if (mem_rd_v && rd_rdy[m_own]) m_left--;
         end else begin
            if (wr_v[m_own]) m_left--;
            else             m_stall++;
         end
         if (m_left == 0) m_busy = 0;
`ifdef MEM_ARB_TIMEOUT_EN
         else if (m_req.op && m_stall == TO) m_busy = 0;
`endif
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 2; i++) begin
         wr_v[i] = 0; wr_d[i] = '0; rd_rdy[i] = 0;
      end
      mem_rd_v = 0; mem_rd_d = '0;
      m_busy = 0; m_issue = 0; m_own = 0; m_last = 1; m_req = '0; m_left = 0; m_stall = 0;
      to_seen = 0; sb_en = 0;
      @(negedge clock);

      // Reset state: every output is zero, even with requests pending.
      push_req(0, 1'b0, 3, 32'h100);
      do_reset();

      // Single read: c0 len 3 at 0x100, data beats 0xA0..0xA3.
      rd_rdy[0] = 1;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         mem_rd_v = 1;
         mem_rd_d = DB'(32'hA0 + i);
         step();
      end
      mem_rd_v = 0;
      step();

      // Tie arbitration from reset: grants must go c0, c1, c0, c1.
      do_reset();
      grant_log.delete();
      wr_v[0] = 1; wr_v[1] = 1;
      for (int i = 0; i < 2; i++) begin
         push_req(0, 1'b1, 0, 32'h10 + i);
         push_req(1, 1'b1, 0, 32'h20 + i);
      end
      repeat (14) step();
      wr_v[0] = 0; wr_v[1] = 0;
      chk("tie_grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         chk("tie_grant_order", grant_log[i], i % 2);

      // Read backpressure: c1 len 1 with rd_ready low for 5 cycles.
      push_req(1, 1'b0, 1, 32'h200);
      mem_rd_v = 1; mem_rd_d = 64'h1111_2222_3333_4444; rd_rdy[1] = 0;
      step();
      step();
      repeat (5) step();
      rd_rdy[1] = 1;
      step();
      mem_rd_d = 64'h5555_6666_7777_8888;
      step();
      mem_rd_v = 0;
      step();

      // Write passthrough: c1 len 1, 0xDEAD, a 2-cycle gap, then 0xBEEF.
      sb_en = 1;
      exp_q.push_back(64'hDEAD);
      exp_q.push_back(64'hBEEF);
      push_req(1, 1'b1, 1, 32'h300);
      step();
      step();
      wr_v[1] = 1; wr_d[1] = 64'hDEAD;
      step();
      wr_v[1] = 0;
      repeat (2) step();
      wr_v[1] = 1; wr_d[1] = 64'hBEEF;
      step();
      wr_v[1] = 0;
      repeat (3) step();
      chk("wr_beats_left", exp_q.size(), 0);
      sb_en = 0;

      // Write with no data: aborted with the macro, held forever without it.
      to_seen = 0;
      push_req(0, 1'b1, 0, 32'h400);
      step();
      step();
      push_req(1, 1'b0, 0, 32'h500);
      repeat (TO) step();
`ifdef MEM_ARB_TIMEOUT_EN
      chk("timeout_pulses", to_seen, 1);
`else
      repeat (24) step();
      chk("write_held", dbg_state, 2'd3);
      chk("timeout_pulses", to_seen, 0);
      wr_v[0] = 1; wr_d[0] = 64'h77;
      step();
      wr_v[0] = 0;
`endif
      mem_rd_v = 1; rd_rdy[1] = 1; mem_rd_d = 64'h500;
      repeat (4) step();
      mem_rd_v = 0;
      step();
      chk("after_timeout_idle", dbg_state, 2'd0);

      // Reset mid-read: reset at beat 2 of a c0 len-7 read.
      push_req(0, 1'b0, 7, 32'h600);
      mem_rd_v = 1; rd_rdy[0] = 1; mem_rd_d = 64'hCAFE;
      repeat (4) step();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      push_req(1, 1'b0, 0, 32'h700);
      repeat (4) step();
      mem_rd_v = 0;
      step();

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 5) == 0 && pq0.size() < 3)
            push_req(0, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 7)),
                     $urandom);
         if ($urandom_range(0, 5) == 0 && pq1.size() < 3)
            push_req(1, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 7)),
                     $urandom);
         for (int i = 0; i < 2; i++) begin
            wr_v[i]   = ($urandom_range(0, 3) != 0);
            wr_d[i]   = {$urandom, $urandom};
            rd_rdy[i] = ($urandom_range(0, 3) != 0);
         end
         mem_rd_v = ($urandom_range(0, 3) != 0);
         mem_rd_d = {$urandom, $urandom};
         step();
      end

      // Drain whatever is still queued or in flight.
      wr_v[0] = 1; wr_v[1] = 1; rd_rdy[0] = 1; rd_rdy[1] = 1; mem_rd_v = 1;
      for (int n = 0; n < 3000 && (m_busy || pq0.size() > 0 || pq1.size() > 0); n++)
         step();
      chk("drain_complete", (m_busy || pq0.size() > 0 || pq1.size() > 0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
